// File: rtl/prog_loader.sv
// Program RAM loader: streams instruction bytes into RAM, CPU fetches via registered port.
// Optional LOADER_CHECKSUM_EN adds a trailing checksum byte and a sticky err flag.
module prog_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] dados,
  output logic              cpu_run,
  output logic              err,
  output logic [ADDR_W:0]   loaded,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    CHECK = 2'b10,
    RUN   = 2'b11
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t st, st_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   len_lat;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_en;
  logic              clr;
  logic              set_err;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_nxt;
  logic              err_q;
  assign sum_nxt = sum + in_data;
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  assign state = st;

  always_comb begin
    st_d     = st;
    in_ready = 1'b0;
    cpu_run  = 1'b0;
    wr_en    = 1'b0;
    clr      = 1'b0;
    set_err  = 1'b0;
    case (st)
      IDLE: begin
        if (start) begin
          st_d = LOAD;
          clr  = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_en = 1'b1;
          if (loaded + ONE == len_lat) begin
`ifdef LOADER_CHECKSUM_EN
            st_d = CHECK;
`else
            st_d = RUN;
`endif
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (sum_nxt == '0) begin
            st_d = RUN;
          end else begin
            st_d    = IDLE;
            set_err = 1'b1;
          end
        end
      end
`endif
      RUN: begin
        cpu_run = 1'b1;
        if (start) begin
          st_d = LOAD;
          clr  = 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      len_lat <= '0;
      wr_addr <= '0;
      loaded  <= '0;
      dados   <= '0;
    end else begin
      st    <= st_d;
      dados <= mem[pc];
      if (clr) begin
        len_lat <= (len == '0) ? FULL : {1'b0, len};
        wr_addr <= '0;
        loaded  <= '0;
      end else if (wr_en) begin
        wr_addr <= wr_addr + ADDR_W'(1);
        loaded  <= loaded + ONE;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (clr) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_en)
        sum <= sum_nxt;
      if (set_err)
        err_q <= 1'b1;
    end
  end
`endif

  // RAM is never reset so a program survives a controller reset
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= in_data;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: transaction-level model plus literal checks.
module tb_prog_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] pc;
  logic [7:0] dados;
  logic       cpu_run;
  logic       err;
  logic [4:0] loaded;
  logic [1:0] state;

  int n_chk = 0;
  int n_fail = 0;

  prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .pc(pc), .dados(dados), .cpu_run(cpu_run), .err(err),
    .loaded(loaded), .state(state)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 loading, 2 awaiting checksum, 3 running
  int         m_ph = 0;
  int         m_left = 0;
  int         m_wa = 0;
  int         m_loaded = 0;
  bit         m_err = 0;
  int         m_sum = 0;
  logic [7:0] m_mem [16];
  bit         m_val [16];
  logic [7:0] m_dados = 8'h00;
  bit         m_dok = 1;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1;
`else
  localparam bit CK = 0;
`endif

  initial for (int i = 0; i < 16; i++) m_val[i] = 0;

  always @(posedge clk or posedge rst) begin
    logic [7:0] rd;
    bit rok;
    if (rst) begin
      m_ph = 0; m_loaded = 0; m_err = 0;
      m_dados = 8'h00; m_dok = 1;
    end else begin
      rd = m_mem[pc];
      rok = m_val[pc];
      if ((m_ph == 0 || m_ph == 3) && start) begin
        m_ph = 1;
        m_left = (len == 0) ? 16 : int'(len);
        m_wa = 0; m_loaded = 0; m_err = 0; m_sum = 0;
      end else if (m_ph == 1 && in_valid) begin
        m_mem[m_wa] = in_data;
        m_val[m_wa] = 1;
        m_wa = (m_wa + 1) % 16;
        m_loaded++;
        m_sum += int'(in_data);
        m_left--;
        if (m_left == 0) m_ph = CK ? 2 : 3;
      end else if (m_ph == 2 && in_valid) begin
        if (((m_sum + int'(in_data)) % 256) == 0) m_ph = 3;
        else begin
          m_ph = 0;
          m_err = 1;
        end
      end
      m_dados = rd;
      m_dok = rok;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_state", 32'(state), 32'(m_ph));
    chk("m_in_ready", 32'(in_ready), 32'(m_ph == 1 || m_ph == 2));
    chk("m_cpu_run", 32'(cpu_run), 32'(m_ph == 3));
    chk("m_loaded", 32'(loaded), 32'(m_loaded));
    chk("m_err", 32'(err), 32'(m_err));
    if (m_dok) chk("m_dados", 32'(dados), 32'(m_dados));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] l);
    start = 1'b1;
    len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bq_t q, input int lo, input int hi, input bit rnd);
    int idx = lo;
    int budget = 0;
    bit acc;
    while (idx < hi && budget < 300) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = q[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    if (idx < hi) begin
      n_chk++;
      n_fail++;
      $display("FAIL feed_timeout: accepted %0d of %0d", idx - lo, hi - lo);
    end
  endtask

  function automatic bq_t with_ck(input bq_t q);
    bq_t r = q;
    logic [7:0] s = 8'h00;
    foreach (q[i]) s = s + q[i];
    if (CK) r.push_back(8'h00 - s);
    return r;
  endfunction

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string nm);
    pc = a;
    tick();
    chk(nm, 32'(dados), 32'(exp));
  endtask

  task automatic sweep;
    for (int a = 0; a < 16; a++) begin
      pc = 4'(a);
      tick();
    end
  endtask

  initial begin
    bq_t q;
    rst = 1'b1; start = 1'b0; len = 4'd0;
    in_valid = 1'b0; in_data = 8'h00; pc = 4'd0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_dados", 32'(dados), 0);
    rst = 1'b0;
    tick();

    // 1: reset mid-stream, then a 3-word load
    do_start(4'd3);
    q = with_ck('{8'h12, 8'h34, 8'h56});
    feed(q, 0, 2, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_state", 32'(state), 0);
    chk("rst_mid_loaded", 32'(loaded), 0);
    chk("rst_mid_ready", 32'(in_ready), 0);
    tick();
    rst = 1'b0;
    tick();
    do_start(4'd3);
    feed(q, 0, q.size(), 0);
    chk("t1_state", 32'(state), 3);
    chk("t1_run", 32'(cpu_run), 1);
    chk("t1_loaded", 32'(loaded), 3);
    rd(4'd1, 8'h34, "t1_dados_pc1");

    // 2: len=0 loads all 16 words, then extra data is refused
    q = {};
    for (int i = 0; i < 16; i++) q.push_back(8'(i));
    q = with_ck(q);
    do_start(4'd0);
    feed(q, 0, q.size(), 0);
    chk("t2_loaded", 32'(loaded), 16);
    in_valid = 1'b1;
    in_data = 8'hEE;
    tick();
    chk("t2_no_17th", 32'(in_ready), 0);
    tick();
    in_valid = 1'b0;
    rd(4'd0, 8'h00, "t2_mem0");
    rd(4'd15, 8'h0F, "t2_mem15");
    sweep();

    // 3: backpressure on a 4-word load
    q = with_ck('{8'hA0, 8'hA1, 8'hA2, 8'hA3});
    do_start(4'd4);
    feed(q, 0, q.size(), 1);
    chk("t3_loaded", 32'(loaded), 4);
    rd(4'd3, 8'hA3, "t3_mem3");
    rd(4'd4, 8'h04, "t3_mem4");
    sweep();

    // 5: reload from RUN
    do_start(4'd1);
    chk("t5_run_drop", 32'(cpu_run), 0);
    chk("t5_state_load", 32'(state), 1);
    q = with_ck('{8'hA5});
    feed(q, 0, q.size(), 0);
    chk("t5_state", 32'(state), 3);
    rd(4'd0, 8'hA5, "t5_mem0");
    rd(4'd1, 8'hA1, "t5_mem1");
    sweep();

    // 6: start during LOAD is ignored
    q = with_ck('{8'hC0, 8'hC1, 8'hC2});
    do_start(4'd3);
    feed(q, 0, 1, 0);
    do_start(4'd1);
    chk("t6_still_load", 32'(state), 1);
    feed(q, 1, q.size(), 0);
    chk("t6_loaded", 32'(loaded), 3);
    chk("t6_state", 32'(state), 3);
    rd(4'd2, 8'hC2, "t6_mem2");

`ifdef LOADER_CHECKSUM_EN
    // 4: checksum pass and fail
    do_start(4'd2);
    q = '{8'h01, 8'h02, 8'hFD};
    feed(q, 0, 3, 0);
    chk("t4_pass_state", 32'(state), 3);
    do_start(4'd2);
    q = '{8'h01, 8'h02, 8'h00};
    feed(q, 0, 3, 0);
    chk("t4_fail_state", 32'(state), 0);
    chk("t4_fail_err", 32'(err), 1);
    chk("t4_fail_run", 32'(cpu_run), 0);
    do_start(4'd2);
    chk("t4_err_clr", 32'(err), 0);
    q = '{8'h01, 8'h02, 8'hFD};
    feed(q, 0, 3, 0);
    chk("t4_recover", 32'(state), 3);
`endif

    sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
